uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter (uart_tx, start/busy interface) between NUM_REQ byte sources. It grants one requester at a time and holds the grant for a whole packet, which ends on a byte flagged last. It pulses start for each byte and waits out the transmitter's busy window. It enforces an optional inter-packet idle gap on the line.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings and a
// constant ceil(log2) helper used to size index and counter fields.
// No logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // ceil(log2(v)); clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set bit of req_i at or above ptr_i, wrapping to 0.
// Purely combinational (0 cycles). No flow control; found_o=0 when req_i is empty.
// Ports: req_i request vector, ptr_i search start, idx_o winner index, found_o any request.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [clog2(NUM_REQ)-1:0] ptr_i,
    output logic [clog2(NUM_REQ)-1:0] idx_o,
    output logic                      found_o
);

    localparam int IW = clog2(NUM_REQ);

    logic [IW:0] pos;

    // Walk offsets from the far end down to 0 so the smallest offset from
    // the pointer is the last match written and therefore wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr_i} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(NUM_REQ)) pos = pos - (IW + 1)'(NUM_REQ);
            if (req_i[pos]) begin
                idx_o   = pos[IW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one start/busy UART transmitter among NUM_REQ byte sources, round-robin per packet.
// Latency: grant 1 clk after request in IDLE; start pulse 1 clk after a ready transfer.
// Backpressure: one-hot o_req_ready only in ISSUE; held off while i_tx_busy, during the gap.
// Ports: i_req_* byte sources, o_req_ready accept, o_tx_start/o_tx_data/i_tx_busy to uart_tx,
//        o_grant_id current owner, o_active packet grant held.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BIT_NUM      = 8,
    parameter int GAP_CYCLES   = 0,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_last,
    input  logic [NUM_REQ*BIT_NUM-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_tx_start,
    output logic [BIT_NUM-1:0]          o_tx_data,
    input  logic                        i_tx_busy,
    output logic [clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                        o_active
);

    localparam int IW = clog2(NUM_REQ);
    localparam int GW = clog2(GAP_CYCLES + 2);
    localparam int TW = clog2(LOCK_TIMEOUT + 2);

    state_t             state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               active_q, active_d;
    logic [BIT_NUM-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic               start_q, start_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [IW-1:0]      ptr_inc;
    logic [BIT_NUM-1:0] sel_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign ptr_inc  = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign sel_data = i_req_data[grant_q*BIT_NUM +: BIT_NUM];

    always_comb begin
        o_req_ready = '0;
        if (state_q == ST_ISSUE) o_req_ready[grant_q] = 1'b1;
    end

    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_grant_id = grant_q;
    assign o_active   = active_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        active_d  = active_q;
        data_d    = data_q;
        last_d    = last_q;
        start_d   = 1'b0;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Busy may still be high from a frame cut short by reset.
                if (!i_tx_busy && pick_found) begin
                    grant_d  = pick_idx;
                    active_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_req_valid[grant_q]) begin
                    data_d  = sel_data;
                    last_d  = i_req_last[grant_q];
                    start_d = 1'b1;
                    state_d = ST_WAIT_ACK;
                end else if (LOCK_TIMEOUT > 0) begin
                    if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        active_d = 1'b0;
                        ptr_d    = ptr_inc;
                        to_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (i_tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        ptr_d     = ptr_inc;
                        active_d  = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            active_q  <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            data_q    <= data_d;
            last_q    <= last_d;
            start_q   <= start_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance A (no gap, no timeout), instance B (gap 5,
// timeout 8), a behavioural uart_tx per instance (busy 10 clks after start),
// and a standalone rr_pick.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    logic [N-1:0]   vld_a, lst_a, rdy_a, vld_b, lst_b, rdy_b;
    logic [N*B-1:0] dat_a, dat_b;
    logic           rst_a, rst_b, start_a, start_b, busy_a, busy_b, act_a, act_b;
    logic [B-1:0]   txd_a, txd_b;
    logic [1:0]     gid_a, gid_b;
    logic           fbusy_a, fbusy_b;
    int             bcnt_a = 0;
    int             bcnt_b = 0;

    // byte sources: per requester FIFO of {last, data}
    logic [8:0] mem_a [N][32];
    logic [8:0] mem_b [N][32];
    int         wr_a [N], rd_a [N], wr_b [N], rd_b [N];

    for (genvar k = 0; k < N; k++) begin : g_src
        assign vld_a[k]        = (rd_a[k] != wr_a[k]);
        assign lst_a[k]        = mem_a[k][rd_a[k] % 32][8];
        assign dat_a[k*B +: B] = mem_a[k][rd_a[k] % 32][7:0];
        assign vld_b[k]        = (rd_b[k] != wr_b[k]);
        assign lst_b[k]        = mem_b[k][rd_b[k] % 32][8];
        assign dat_b[k*B +: B] = mem_b[k][rd_b[k] % 32][7:0];
    end

    always @(posedge clk) begin
        if (start_a) bcnt_a <= 10; else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
        if (start_b) bcnt_b <= 10; else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    end
    assign busy_a = (bcnt_a != 0) | fbusy_a;
    assign busy_b = (bcnt_b != 0) | fbusy_b;

    uart_tx_arbiter #(.NUM_REQ(N), .BIT_NUM(B), .GAP_CYCLES(0), .LOCK_TIMEOUT(0)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_req_valid(vld_a), .i_req_last(lst_a),
        .i_req_data(dat_a), .o_req_ready(rdy_a), .o_tx_start(start_a),
        .o_tx_data(txd_a), .i_tx_busy(busy_a), .o_grant_id(gid_a), .o_active(act_a)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .BIT_NUM(B), .GAP_CYCLES(5), .LOCK_TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_req_valid(vld_b), .i_req_last(lst_b),
        .i_req_data(dat_b), .o_req_ready(rdy_b), .o_tx_start(start_b),
        .o_tx_data(txd_b), .i_tx_busy(busy_b), .o_grant_id(gid_b), .o_active(act_b)
    );

    logic [3:0] pk_req;
    logic [1:0] pk_ptr, pk_idx;
    logic       pk_found;
    rr_pick #(.NUM_REQ(N)) u_pk (
        .req_i(pk_req), .ptr_i(pk_ptr), .idx_o(pk_idx), .found_o(pk_found)
    );

    // start-pulse log filled by collect()
    logic [7:0] log_d [16];
    logic [1:0] log_g [16];
    int         log_c [16];
    int         log_n, bad_hot, last_bfall, last_afall;

    task automatic push_a(input int k, input logic [7:0] d, input logic l);
        mem_a[k][wr_a[k] % 32] = {l, d};
        wr_a[k]++;
    endtask

    task automatic push_b(input int k, input logic [7:0] d, input logic l);
        mem_b[k][wr_b[k] % 32] = {l, d};
        wr_b[k]++;
    endtask

    // Advance one clock: entered and left at a negedge; pops source bytes
    // accepted at the posedge.
    task automatic cyc();
        logic [N-1:0] xa, xb;
        xa = vld_a & rdy_a;
        xb = vld_b & rdy_b;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (xa[k]) rd_a[k]++;
            if (xb[k]) rd_b[k]++;
        end
        @(negedge clk);
        cyc_no++;
    endtask

    // Run until nst start pulses are logged (and, with wait_idle, the grant is dropped).
    task automatic collect(input bit sb, input int nst, input bit wait_idle, input int maxc);
        logic [N-1:0] r;
        logic         s, a, bz, pa, pb, done;
        logic [1:0]   g;
        logic [7:0]   d;
        done = 1'b0;
        pa = sb ? act_b : act_a;
        pb = sb ? busy_b : busy_a;
        for (int c = 0; c < maxc; c++) begin
            cyc();
            r  = sb ? rdy_b : rdy_a;
            s  = sb ? start_b : start_a;
            a  = sb ? act_b : act_a;
            bz = sb ? busy_b : busy_a;
            g  = sb ? gid_b : gid_a;
            d  = sb ? txd_b : txd_a;
            if (r != '0 && (r != (4'b0001 << g) || !a)) bad_hot++;
            if (pb && !bz) last_bfall = cyc_no;
            if (pa && !a) last_afall = cyc_no;
            pa = a;
            pb = bz;
            if (s && log_n < 16) begin
                log_d[log_n] = d;
                log_g[log_n] = g;
                log_c[log_n] = cyc_no;
                log_n++;
            end
            if (log_n >= nst && (!wait_idle || !a)) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL collect_timeout got starts=%0d exp=%0d", log_n, nst);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({rdy_a, start_a, txd_a, gid_a, act_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got rdy=%b st=%b d=%h g=%0d act=%b exp all 0", rdy_a, start_a, txd_a, gid_a, act_a);
        end
        checks++;
        if ({rdy_b, start_b, txd_b, gid_b, act_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got rdy=%b st=%b d=%h g=%0d act=%b exp all 0", rdy_b, start_b, txd_b, gid_b, act_b);
        end
        cyc();
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({rdy_a, start_a, act_a, rdy_b, start_b, act_b} !== '0) begin
            errors++;
            $display("FAIL idle_no_req got rdy_a=%b act_a=%b rdy_b=%b act_b=%b exp 0", rdy_a, act_a, rdy_b, act_b);
        end
    endtask

    task automatic test_rr_pick();
        logic [8:0] vec [8];
        // {req, ptr, idx, found}
        vec[0] = {4'b0000, 2'd0, 2'd0, 1'b0};
        vec[1] = {4'b0001, 2'd3, 2'd0, 1'b1};
        vec[2] = {4'b1010, 2'd2, 2'd3, 1'b1};
        vec[3] = {4'b1010, 2'd0, 2'd1, 1'b1};
        vec[4] = {4'b0110, 2'd3, 2'd1, 1'b1};
        vec[5] = {4'b1111, 2'd2, 2'd2, 1'b1};
        vec[6] = {4'b1000, 2'd3, 2'd3, 1'b1};
        vec[7] = {4'b0101, 2'd1, 2'd2, 1'b1};
        for (int i = 0; i < 8; i++) begin
            pk_req = vec[i][8:5];
            pk_ptr = vec[i][4:3];
            #1;
            checks++;
            if ({pk_idx, pk_found} !== vec[i][2:0]) begin
                errors++;
                $display("FAIL rr_pick_%0d got idx=%0d found=%b exp idx=%0d found=%b",
                         i, pk_idx, pk_found, vec[i][2:1], vec[i][0]);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] expd [3];
        expd[0] = 8'h41; expd[1] = 8'h42; expd[2] = 8'h43;
        log_n = 0;
        push_a(1, 8'h41, 1'b0);
        push_a(1, 8'h42, 1'b0);
        push_a(1, 8'h43, 1'b1);
        collect(1'b0, 3, 1'b1, 300);
        checks++;
        if (log_n != 3) begin
            errors++;
            $display("FAIL t1_starts got=%0d exp=3", log_n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_d[i] !== expd[i] || log_g[i] !== 2'd1) begin
                errors++;
                $display("FAIL t1_byte%0d got d=%h g=%0d exp d=%h g=1", i, log_d[i], log_g[i], expd[i]);
            end
        end
        // one 10-clk frame plus 3 clks between starts
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (log_c[i] - log_c[i-1] != 13) begin
                errors++;
                $display("FAIL t1_spacing%0d got=%0d exp=13", i, log_c[i] - log_c[i-1]);
            end
        end
        checks++;
        if (last_afall - last_bfall != 1) begin
            errors++;
            $display("FAIL t1_active_fall got=%0d exp=1 clk after busy fall", last_afall - last_bfall);
        end
        // pointer now 2: with 0 and 2 both pending, 2 goes first
        log_n = 0;
        push_a(0, 8'h50, 1'b1);
        push_a(2, 8'h52, 1'b1);
        collect(1'b0, 2, 1'b1, 300);
        checks++;
        if (log_g[0] !== 2'd2 || log_g[1] !== 2'd0 || log_d[0] !== 8'h52 || log_d[1] !== 8'h50) begin
            errors++;
            $display("FAIL t1_ptr got g=%0d,%0d d=%h,%h exp g=2,0 d=52,50", log_g[0], log_g[1], log_d[0], log_d[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expg [5];
        logic [7:0] expd [5];
        expg[0] = 2'd0; expg[1] = 2'd1; expg[2] = 2'd2; expg[3] = 2'd3; expg[4] = 2'd0;
        expd[0] = 8'hA0; expd[1] = 8'hA1; expd[2] = 8'hA2; expd[3] = 8'hA3; expd[4] = 8'hA4;
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        log_n = 0;
        bad_hot = 0;
        push_a(0, 8'hA0, 1'b1);
        push_a(0, 8'hA4, 1'b1);
        push_a(1, 8'hA1, 1'b1);
        push_a(2, 8'hA2, 1'b1);
        push_a(3, 8'hA3, 1'b1);
        collect(1'b0, 5, 1'b1, 400);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_g[i] !== expg[i] || log_d[i] !== expd[i]) begin
                errors++;
                $display("FAIL t2_grant%0d got g=%0d d=%h exp g=%0d d=%h", i, log_g[i], log_d[i], expg[i], expd[i]);
            end
        end
        checks++;
        if (bad_hot != 0) begin
            errors++;
            $display("FAIL t2_ready_onehot got bad_cycles=%0d exp=0", bad_hot);
        end
    endtask

    task automatic test_hold_grant();
        log_n = 0;
        bad_hot = 0;
        push_a(2, 8'hC0, 1'b0);
        push_a(2, 8'hC1, 1'b0);
        push_a(2, 8'hC2, 1'b1);
        collect(1'b0, 1, 1'b0, 100);
        push_a(0, 8'hD0, 1'b1);
        collect(1'b0, 4, 1'b1, 300);
        checks++;
        if (log_g[0] !== 2'd2 || log_g[1] !== 2'd2 || log_g[2] !== 2'd2 || log_g[3] !== 2'd0) begin
            errors++;
            $display("FAIL t3_hold got g=%0d,%0d,%0d,%0d exp 2,2,2,0", log_g[0], log_g[1], log_g[2], log_g[3]);
        end
        checks++;
        if (log_d[2] !== 8'hC2 || log_d[3] !== 8'hD0) begin
            errors++;
            $display("FAIL t3_data got %h,%h exp C2,D0", log_d[2], log_d[3]);
        end
        checks++;
        if (bad_hot != 0) begin
            errors++;
            $display("FAIL t3_ready_onehot got bad_cycles=%0d exp=0", bad_hot);
        end
    endtask

    task automatic test_gap();
        int k, n, actbad;
        push_b(0, 8'h60, 1'b1);
        push_b(1, 8'h61, 1'b1);
        k = 0;
        while (!busy_b && k < 100) begin cyc(); k++; end
        while (busy_b && k < 100) begin cyc(); k++; end
        // now at the first clock with busy low after the last byte
        n = 0;
        actbad = 0;
        while (rdy_b == '0 && n < 50) begin
            cyc();
            n++;
            if (rdy_b == '0 && act_b) actbad++;
        end
        // 5 gap clocks, then the IDLE arbitration clock, then ISSUE
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL t4_gap got=%0d exp=7 clks from busy fall to ready", n);
        end
        checks++;
        if (rdy_b !== 4'b0010 || actbad != 0) begin
            errors++;
            $display("FAIL t4_next got rdy=%b actbad=%0d exp rdy=0010 actbad=0", rdy_b, actbad);
        end
        log_n = 0;
        collect(1'b1, 1, 1'b1, 200);
        checks++;
        if (log_d[0] !== 8'h61 || log_g[0] !== 2'd1) begin
            errors++;
            $display("FAIL t4_drain got d=%h g=%0d exp d=61 g=1", log_d[0], log_g[0]);
        end
    endtask

    task automatic test_lock_timeout();
        int n, bad2;
        log_n = 0;
        push_b(1, 8'h71, 1'b0);
        collect(1'b1, 1, 1'b0, 100);
        checks++;
        if (log_g[0] !== 2'd1 || log_d[0] !== 8'h71) begin
            errors++;
            $display("FAIL t5_first got g=%0d d=%h exp g=1 d=71", log_g[0], log_d[0]);
        end
        push_b(2, 8'h72, 1'b1);
        n = 0;
        bad2 = 0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (rdy_b[1]) n++;
            if (rdy_b[2]) bad2++;
            if (!act_b) break;
        end
        checks++;
        if (n != 8 || bad2 != 0) begin
            errors++;
            $display("FAIL t5_timeout got ready_clks=%0d other=%0d exp 8,0", n, bad2);
        end
        log_n = 0;
        collect(1'b1, 1, 1'b1, 200);
        checks++;
        if (log_g[0] !== 2'd2 || log_d[0] !== 8'h72) begin
            errors++;
            $display("FAIL t5_next got g=%0d d=%h exp g=2 d=72", log_g[0], log_d[0]);
        end
    endtask

    task automatic test_reset_mid_packet();
        int hold_bad;
        log_n = 0;
        push_a(1, 8'h81, 1'b1);
        collect(1'b0, 1, 1'b1, 200);
        log_n = 0;
        push_a(2, 8'h82, 1'b0);
        push_a(2, 8'h83, 1'b1);
        collect(1'b0, 1, 1'b0, 100);
        cyc();
        cyc();
        // in WAIT_DONE with busy high
        fbusy_a = 1'b1;
        rst_a   = 1'b1;
        #1;
        checks++;
        if ({rdy_a, start_a, txd_a, gid_a, act_a} !== '0) begin
            errors++;
            $display("FAIL t6_async_reset got rdy=%b st=%b d=%h g=%0d act=%b exp all 0", rdy_a, start_a, txd_a, gid_a, act_a);
        end
        for (int k = 0; k < N; k++) rd_a[k] = wr_a[k];
        @(negedge clk);
        cyc();
        rst_a = 1'b0;
        push_a(0, 8'h90, 1'b1);
        push_a(3, 8'h93, 1'b1);
        hold_bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (act_a || rdy_a != '0 || start_a) hold_bad++;
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL t6_busy_hold got grant_clks=%0d exp=0", hold_bad);
        end
        fbusy_a = 1'b0;
        log_n = 0;
        collect(1'b0, 2, 1'b1, 300);
        checks++;
        if (log_g[0] !== 2'd0 || log_d[0] !== 8'h90 || log_g[1] !== 2'd3) begin
            errors++;
            $display("FAIL t6_after_reset got g=%0d,%0d d=%h exp g=0,3 d=90", log_g[0], log_g[1], log_d[0]);
        end
    endtask

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        fbusy_a = 1'b0;
        fbusy_b = 1'b0;
        pk_req  = '0;
        pk_ptr  = '0;
        log_n   = 0;
        bad_hot = 0;
        last_bfall = 0;
        last_afall = 0;
        for (int k = 0; k < N; k++) begin
            wr_a[k] = 0; rd_a[k] = 0; wr_b[k] = 0; rd_b[k] = 0;
            for (int j = 0; j < 32; j++) begin
                mem_a[k][j] = '0;
                mem_b[k][j] = '0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_rr_pick();
        test_single_packet();
        test_round_robin();
        test_hold_grant();
        test_gap();
        test_lock_timeout();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
